// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: boots from RESET_PC, steps by 4, takes EX/ID
// redirects with squash signals, parks a redirect while imem is busy, and
// halts permanently on a misaligned target.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        ex_redirect_i,
   input  logic [31:0] ex_target_i,
   input  logic        id_jump_i,
   input  logic [31:0] id_target_i,
   input  logic        imem_ready_i,
   output logic [31:0] pc_o,
   output logic        imem_req_o,
   output logic        flush_ifid_o,
   output logic        flush_idex_o,
   output logic        misaligned_o,
   output logic [15:0] redirect_cnt_o
);

   typedef enum logic [1:0] {BOOT, RUN, PEND, HALT} state_t;

   state_t      state;
   logic [31:0] pend_target;
   logic        take;
   logic [31:0] target;

   // Decode the winning redirect this cycle and raise the matching squashes.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      take         = 1'b0;
      target       = ex_target_i;
      flush_ifid_o = 1'b0;
      flush_idex_o = 1'b0;
      case (state)
         RUN: begin
            if (ex_redirect_i) begin
               take         = 1'b1;
               flush_ifid_o = 1'b1;
               flush_idex_o = 1'b1;
            end else if (id_jump_i) begin
               take         = 1'b1;
               target       = id_target_i;
               flush_ifid_o = 1'b1;
            end
         end
         PEND: begin
            // A JAL in ID is already on the wrong path here; only EX can redirect.
            if (ex_redirect_i) begin
               take         = 1'b1;
               flush_ifid_o = 1'b1;
               flush_idex_o = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // FSM, fetch address, pending target, trap flag and redirect counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the pending target is reset too, so a redirect caught in
         // flight can never leak out of a reset into the fetch stream.
         state          <= BOOT;
         pc_o           <= RESET_PC;
         pend_target    <= 32'h0;
         imem_req_o     <= 1'b0;
         misaligned_o   <= 1'b0;
         redirect_cnt_o <= 16'h0;
      end else begin
         // NOTE: all state here uses non-blocking assignment so every
         // register samples the pre-edge values of the others.
         case (state)
            BOOT: begin
               state      <= RUN;
               imem_req_o <= 1'b1;
            end
            RUN, PEND: begin
               if (take) begin
                  if (redirect_cnt_o != 16'hFFFF)
                     redirect_cnt_o <= redirect_cnt_o + 16'd1;
                  if (target[1:0] != 2'b00) begin
                     state        <= HALT;
                     misaligned_o <= 1'b1;
                     imem_req_o   <= 1'b0;
                  end else if (imem_ready_i) begin
                     pc_o  <= target;
                     state <= RUN;
                  end else begin
                     pend_target <= target;
                     state       <= PEND;
                  end
               end else if (state == PEND) begin
                  if (imem_ready_i) begin
                     pc_o  <= pend_target;
                     state <= RUN;
                  end
               end else if (imem_ready_i && !stall_i) begin
                  pc_o <= pc_o + 32'd4;
               end
            end
            default: ;  // HALT: only reset leaves
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch sequencer.
module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, ex_redirect_i, id_jump_i, imem_ready_i;
   logic [31:0] ex_target_i, id_target_i;
   logic [31:0] pc_o;
   logic        imem_req_o, flush_ifid_o, flush_idex_o, misaligned_o;
   logic [15:0] redirect_cnt_o;

   pc_sequencer #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
      .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i),
      .id_jump_i(id_jump_i), .id_target_i(id_target_i),
      .imem_ready_i(imem_ready_i), .pc_o(pc_o), .imem_req_o(imem_req_o),
      .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
      .misaligned_o(misaligned_o), .redirect_cnt_o(redirect_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: mode 0 booting, 1 fetching, 2 waiting on a parked
   // redirect, 3 trapped.
   int          m_mode;
   longint      m_pc;
   longint      m_pend;
   int          m_cnt;
   bit          m_mis;
   bit          exp_ifid, exp_idex;
   logic        obs_ifid, obs_idex;

   task automatic model_reset();
      m_mode = 0; m_pc = RESET_PC; m_pend = 0; m_cnt = 0; m_mis = 0;
   endtask

   function automatic bit m_req();
      return (m_mode == 1) || (m_mode == 2);
   endfunction

   task automatic model_step(input bit s, input bit e, input longint et,
                             input bit j, input longint jt, input bit r);
      longint tgt;
      bit     have;
      have = 0; tgt = 0;
      if (m_mode == 1 && (e || j)) begin have = 1; tgt = e ? et : jt; end
      if (m_mode == 2 && e)        begin have = 1; tgt = et; end
      if (m_mode == 0) m_mode = 1;
      else if (have) begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (tgt % 4 != 0) begin m_mode = 3; m_mis = 1; end
         else if (r) begin m_pc = tgt; m_mode = 1; end
         else begin m_pend = tgt; m_mode = 2; end
      end else if (m_mode == 2 && r) begin
         m_pc = m_pend; m_mode = 1;
      end else if (m_mode == 1 && r && !s) begin
         m_pc = (m_pc + 4) % 64'h1_0000_0000;
      end
   endtask

   // One clock: drive inputs, sample the combinational flushes mid-cycle,
   // then advance the model across the rising edge.
   task automatic cycle(input bit s, input bit e, input logic [31:0] et,
                        input bit j, input logic [31:0] jt, input bit r);
      stall_i = s; ex_redirect_i = e; ex_target_i = et;
      id_jump_i = j; id_target_i = jt; imem_ready_i = r;
      exp_ifid = ((m_mode == 1) && (e || j)) || ((m_mode == 2) && e);
      exp_idex = ((m_mode == 1) || (m_mode == 2)) && e;
      @(negedge clk);
      obs_ifid = flush_ifid_o;
      obs_idex = flush_idex_o;
      @(posedge clk);
      model_step(s, e, longint'(et), j, longint'(jt), r);
      #1;
   endtask

   task automatic idle(input bit r);
      cycle(0, 0, 32'h0, 0, 32'h0, r);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stall_i = 0; ex_redirect_i = 0; id_jump_i = 0; imem_ready_i = 1;
      ex_target_i = 0; id_target_i = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (pc_o !== RESET_PC || imem_req_o !== 1'b0 || misaligned_o !== 1'b0 ||
          redirect_cnt_o !== 16'h0 || flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: pc=%h req=%b mis=%b cnt=%0d fl=%b%b, want pc=%h others 0",
                  pc_o, imem_req_o, misaligned_o, redirect_cnt_o, flush_ifid_o, flush_idex_o, RESET_PC);
      end
      rst_n = 1'b1;
      // Boot cycle: a redirect here must be ignored and no flush raised.
      cycle(0, 1, 32'h0000_0400, 1, 32'h0000_0500, 1);
      n_checks++;
      if (obs_ifid !== 1'b0 || obs_idex !== 1'b0) begin
         n_fail++;
         $display("FAIL boot_flush: got %b%b, want 00", obs_ifid, obs_idex);
      end
   endtask

   task automatic test_sequential();
      n_checks++;
      if (imem_req_o !== 1'b1 || pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL seq_start: req=%b pc=%h, want req=1 pc=0", imem_req_o, pc_o);
      end
      for (int i = 1; i <= 3; i++) begin
         idle(1);
         n_checks++;
         if (pc_o !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL seq_pc%0d: got %h, want %h", i, pc_o, 32'(4 * i));
         end
      end
   endtask

   task automatic test_simultaneous();
      while (pc_o < 32'h20) idle(1);
      n_checks++;
      if (pc_o !== 32'h20) begin
         n_fail++;
         $display("FAIL simul_setup: pc=%h, want 00000020", pc_o);
      end
      cycle(1, 1, 32'h100, 1, 32'h200, 1);
      n_checks++;
      if (obs_ifid !== 1'b1 || obs_idex !== 1'b1 || pc_o !== 32'h100 || redirect_cnt_o !== 16'd1) begin
         n_fail++;
         $display("FAIL simul_events: fl=%b%b pc=%h cnt=%0d, want fl=11 pc=00000100 cnt=1",
                  obs_ifid, obs_idex, pc_o, redirect_cnt_o);
      end
      idle(1);
      n_checks++;
      if (obs_ifid !== 1'b0 || obs_idex !== 1'b0 || pc_o !== 32'h104) begin
         n_fail++;
         $display("FAIL simul_after: fl=%b%b pc=%h, want fl=00 pc=00000104", obs_ifid, obs_idex, pc_o);
      end
   endtask

   task automatic test_wrap();
      cycle(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
      n_checks++;
      if (obs_ifid !== 1'b1 || obs_idex !== 1'b0 || pc_o !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL id_jump: fl=%b%b pc=%h, want fl=10 pc=fffffffc", obs_ifid, obs_idex, pc_o);
      end
      idle(1);
      n_checks++;
      if (pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap: got %h, want 00000000", pc_o);
      end
   endtask

   task automatic test_pending();
      int cnt0;
      cnt0 = m_cnt;
      cycle(0, 0, 32'h0, 1, 32'h40, 0);
      n_checks++;
      if (obs_ifid !== 1'b1 || obs_idex !== 1'b0 || pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL pend_enter: fl=%b%b pc=%h, want fl=10 pc=00000000", obs_ifid, obs_idex, pc_o);
      end
      // Overwrite with EX; the concurrent JAL and stall are wrong-path.
      cycle(1, 1, 32'h80, 1, 32'hC0, 0);
      n_checks++;
      if (obs_ifid !== 1'b1 || obs_idex !== 1'b1 || imem_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL pend_overwrite: fl=%b%b req=%b, want fl=11 req=1", obs_ifid, obs_idex, imem_req_o);
      end
      cycle(1, 0, 32'h0, 1, 32'hC0, 1);
      n_checks++;
      if (obs_ifid !== 1'b0 || obs_idex !== 1'b0 || pc_o !== 32'h80 ||
          redirect_cnt_o !== 16'(cnt0 + 2)) begin
         n_fail++;
         $display("FAIL pend_release: fl=%b%b pc=%h cnt=%0d, want fl=00 pc=00000080 cnt=%0d",
                  obs_ifid, obs_idex, pc_o, redirect_cnt_o, cnt0 + 2);
      end
   endtask

   task automatic test_random();
      bit s, e, j, r;
      logic [31:0] et, jt;
      for (int i = 0; i < 400; i++) begin
         s  = ($urandom_range(0, 3) == 0);
         e  = ($urandom_range(0, 6) == 0);
         j  = ($urandom_range(0, 6) == 0);
         r  = ($urandom_range(0, 3) != 0);
         et = $urandom & 32'hFFFF_FFFC;
         jt = $urandom & 32'hFFFF_FFFC;
         cycle(s, e, et, j, jt, r);
         n_checks++;
         if (obs_ifid !== exp_ifid || obs_idex !== exp_idex || pc_o !== 32'(m_pc) ||
             imem_req_o !== m_req() || redirect_cnt_o !== 16'(m_cnt) || misaligned_o !== m_mis) begin
            n_fail++;
            $display("FAIL random[%0d]: fl=%b%b pc=%h req=%b cnt=%0d mis=%b, want fl=%b%b pc=%h req=%b cnt=%0d mis=%b",
                     i, obs_ifid, obs_idex, pc_o, imem_req_o, redirect_cnt_o, misaligned_o,
                     exp_ifid, exp_idex, 32'(m_pc), m_req(), m_cnt, m_mis);
         end
      end
      while (m_mode != 1) idle(1);
   endtask

   task automatic test_misaligned();
      logic [31:0] frozen;
      frozen = pc_o;
      cycle(0, 1, 32'h102, 0, 32'h0, 1);
      n_checks++;
      if (obs_ifid !== 1'b1 || obs_idex !== 1'b1 || misaligned_o !== 1'b1 ||
          imem_req_o !== 1'b0 || pc_o !== frozen) begin
         n_fail++;
         $display("FAIL misaligned_trap: fl=%b%b mis=%b req=%b pc=%h, want fl=11 mis=1 req=0 pc=%h",
                  obs_ifid, obs_idex, misaligned_o, imem_req_o, pc_o, frozen);
      end
      for (int i = 0; i < 12; i++) begin
         cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
         n_checks++;
         if (pc_o !== frozen || misaligned_o !== 1'b1 || imem_req_o !== 1'b0 ||
             obs_ifid !== 1'b0 || obs_idex !== 1'b0 || redirect_cnt_o !== 16'(m_cnt)) begin
            n_fail++;
            $display("FAIL halt_hold[%0d]: pc=%h mis=%b req=%b fl=%b%b cnt=%0d, want pc=%h mis=1 req=0 fl=00 cnt=%0d",
                     i, pc_o, misaligned_o, imem_req_o, obs_ifid, obs_idex, redirect_cnt_o, frozen, m_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #2;
      model_reset();
      rst_n = 1'b1;
      idle(1);  // boot
      idle(1);
      idle(1);
      cycle(0, 0, 32'h0, 1, 32'h300, 0);
      n_checks++;
      if (imem_req_o !== 1'b1 || pc_o === 32'h300) begin
         n_fail++;
         $display("FAIL mid_setup: req=%b pc=%h, want req=1 pc!=00000300", imem_req_o, pc_o);
      end
      // Assert reset between edges; the outputs must fall back at once.
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (pc_o !== RESET_PC || imem_req_o !== 1'b0 || redirect_cnt_o !== 16'h0) begin
         n_fail++;
         $display("FAIL mid_async: pc=%h req=%b cnt=%0d, want pc=%h req=0 cnt=0",
                  pc_o, imem_req_o, redirect_cnt_o, RESET_PC);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      n_checks++;
      if (imem_req_o !== 1'b1 || pc_o !== RESET_PC) begin
         n_fail++;
         $display("FAIL mid_boot: req=%b pc=%h, want req=1 pc=%h", imem_req_o, pc_o, RESET_PC);
      end
      for (int i = 0; i < 20; i++) begin
         idle(1);
         n_checks++;
         if (pc_o === 32'h300 || pc_o !== 32'(m_pc)) begin
            n_fail++;
            $display("FAIL mid_no_stale[%0d]: pc=%h, want %h", i, pc_o, 32'(m_pc));
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_simultaneous();
      test_wrap();
      test_pending();
      test_random();
      test_misaligned();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch address loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port stall_i, input, 1 bit: load-use stall; hold the PC.
REQ-005 The block SHALL have port ex_redirect_i, input, 1 bit: a taken branch or JALR resolved in EX.
REQ-006 The block SHALL have port ex_target_i, input, 32 bits: the EX redirect target (PC plus SB immediate, or the JALR sum).
REQ-007 The block SHALL have port id_jump_i, input, 1 bit: a JAL decoded in ID.
REQ-008 The block SHALL have port id_target_i, input, 32 bits: the JAL target (PC plus UJ immediate).
REQ-009 The block SHALL have port imem_ready_i, input, 1 bit: instruction memory accepted the current fetch.
REQ-010 The block SHALL have port pc_o, output, 32 bits: registered fetch address.
REQ-011 The block SHALL have port imem_req_o, output, 1 bit: fetch request is valid.
REQ-012 The block SHALL have port flush_ifid_o, output, 1 bit: squash the IF/ID register this cycle.
REQ-013 The block SHALL have port flush_idex_o, output, 1 bit: squash the ID/EX register this cycle.
REQ-014 The block SHALL have port misaligned_o, output, 1 bit: a misaligned target was trapped.
REQ-015 The block SHALL have port redirect_cnt_o, output, 16 bits: saturating count of accepted redirects.

Function
REQ-016 The FSM SHALL have exactly four states: BOOT, RUN, PEND, HALT.
REQ-017 BOOT SHALL last exactly one cycle after rst_n deasserts, with imem_req_o=0, then move to RUN.
REQ-018 In RUN and PEND, imem_req_o SHALL be 1; in BOOT and HALT it SHALL be 0.
REQ-019 Event priority in RUN SHALL be, highest first: ex_redirect_i, id_jump_i, stall_i, sequential.
REQ-020 In RUN with imem_ready_i=1, an EX redirect SHALL load pc_o with ex_target_i on the next edge, and assert flush_ifid_o and flush_idex_o combinationally in the accepting cycle.
REQ-021 In RUN with imem_ready_i=1, an ID jump (no EX redirect) SHALL load pc_o with id_target_i on the next edge, and assert flush_ifid_o only.
REQ-022 In RUN with imem_ready_i=1, stall_i=1 and no redirect, pc_o SHALL hold; both flushes SHALL be 0.
REQ-023 In RUN with imem_ready_i=1 and no event, pc_o SHALL become pc_o+4, modulo 2^32, so that 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 In RUN with imem_ready_i=0, pc_o SHALL hold.
REQ-025 A redirect arriving with imem_ready_i=0 SHALL be latched into a pending target register, assert its flushes that cycle, and move the FSM to PEND.
REQ-026 In PEND:
- an EX redirect SHALL overwrite the pending target and assert both flushes again;
- id_jump_i SHALL be ignored (wrong path);
- stall_i SHALL be ignored.
REQ-027 In PEND with imem_ready_i=1, pc_o SHALL load the pending target (or the same-cycle EX target, if present) and the FSM SHALL return to RUN.
REQ-028 Flush outputs SHALL be 0 in BOOT and HALT.
REQ-029 A target accepted with bits[1:0]!=0 SHALL move the FSM to HALT and set misaligned_o=1.
- In that case pc_o holds its current value, and the flushes for that cycle still assert.
REQ-030 HALT SHALL be exited only by reset; all inputs SHALL be ignored in HALT.
REQ-031 redirect_cnt_o SHALL increment by 1 per accepted redirect, including PEND overwrites, and saturate at 16'hFFFF.
REQ-032 A stall and a redirect asserted in the same cycle SHALL resolve as the redirect, with the stall dropped.

Reset
REQ-033 On rst_n=0, asynchronously, the block SHALL set:
- pc_o=RESET_PC
- state=BOOT
- imem_req_o=0
- misaligned_o=0
- redirect_cnt_o=0
- pending target=0
- flush_ifid_o=0 and flush_idex_o=0
REQ-034 Reset asserted in any state, including PEND or HALT, SHALL discard any pending redirect and take effect without waiting for a clock edge.

Verification
REQ-035 Sequential fetch: release reset with RESET_PC=0 and imem_ready_i=1 held -> imem_req_o rises on cycle 2, and pc_o runs 0, 4, 8, 12.
REQ-036 Wrap-around: force pc_o to 0xFFFF_FFFC -> next pc_o=0x0000_0000.
REQ-037 Simultaneous events: at pc_o=0x20, assert ex_redirect_i (target 0x100), id_jump_i (target 0x200) and stall_i together -> pc_o=0x100, flush_ifid_o=1 and flush_idex_o=1 for one cycle, redirect_cnt_o=1.
REQ-038 Pending redirect: with imem_ready_i=0, sequence:
- ID jump to 0x40 -> PEND, flush_ifid_o pulses;
- next cycle, EX redirect to 0x80 -> both flushes pulse;
- then imem_ready_i=1 -> pc_o=0x80, redirect_cnt_o=2.
REQ-039 Misaligned target: EX redirect to 0x102 -> misaligned_o=1, imem_req_o=0, and pc_o frozen for 10+ cycles regardless of inputs.
REQ-040 Reset mid-operation: assert rst_n=0 while in PEND -> pc_o=RESET_PC immediately; after release the block passes through BOOT, and the old pending target is never fetched.
